// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, mux selects
// and the bundle of control outputs driven into the datapath.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outputs.sv
// Combinational decode of (state, mem_ready, opcode) into the datapath control bundle.
// FETCH and MEM_WRITE carry Mealy terms gated by mem_ready; DECODE flags illegal opcodes.
module multicycle_ctrl_outputs
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_t              state,
    input  logic                mem_ready,
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BRANCH only needs the compare
                ctrl.alu_src_b  = SRCB_IMM_SL2;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !is_legal_op(opcode);
                ctrl.instr_done = !is_legal_op(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RD2;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle datapath: state register and next-state logic,
// with the output decode delegated to multicycle_ctrl_outputs.
module multicycle_main_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic                instr_done,
    output logic [STATE_W-1:0]  state
);

    state_t state_q, state_d;
    logic   active_q, active_d;
    ctrl_t  ctrl_raw, ctrl_out;

    // active_q keeps every output low (and the FSM parked) until the first edge after reset
    always_comb begin
        active_d = 1'b1;
        state_d  = state_q;
        if (active_q) begin
            case (state_q)
                S_FETCH:     if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEM_ADDR;
                    else if (Opcode == OP_RTYPE)            state_d = S_EXECUTE;
                    else if (Opcode == OP_BEQ)              state_d = S_BRANCH;
                    else if (Opcode == OP_J)                state_d = S_JUMP;
                    else if (Opcode == OP_ADDI)             state_d = S_ADDI_EXEC;
                    else                                    state_d = S_FETCH;
                end
                S_MEM_ADDR:  state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
                S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
                S_EXECUTE:   state_d = S_ALU_WB;
                S_ADDI_EXEC: state_d = S_ADDI_WB;
                default:     state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    multicycle_ctrl_outputs #(
        .OPCODE_W (OPCODE_W)
    ) u_outputs (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (Opcode),
        .ctrl      (ctrl_raw)
    );

    assign ctrl_out    = active_q ? ctrl_raw : '0;
    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign IorD        = ctrl_out.iord;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign IRWrite     = ctrl_out.ir_write;
    assign MemtoReg    = ctrl_out.mem_to_reg;
    assign RegDst      = ctrl_out.reg_dst;
    assign RegWrite    = ctrl_out.reg_write;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ALUOp       = ctrl_out.alu_op;
    assign PCSource    = ctrl_out.pc_source;
    assign illegal_op  = ctrl_out.illegal_op;
    assign instr_done  = ctrl_out.instr_done;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: per-instruction state-sequence model,
// vector table, directed stall/reset sequences and randomized mem_ready traffic.
module tb_multicycle_main_control;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic ill, done;
    } outs_t;

    typedef struct {
        logic [5:0]  op;
        int          lat;
        logic [23:0] states;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, mem_ready;
    logic [5:0] Opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, instr_done;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    multicycle_main_control #(.OPCODE_W(6), .STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .instr_done(instr_done),
        .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    outs_t base [12];
    int mseq[$];
    int mpos;
    logic [5:0] mop;
    logic instr_end;
    int k, done_cnt, done_idx, irw_cnt, irw_idx, fetch_rd_cnt, mwr_cnt;
    logic [23:0] obs_pack;
    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic outs_t get_outs();
        outs_t o;
        o.pcw = PCWrite;  o.pcwc = PCWriteCond; o.iord = IorD;  o.mrd = MemRead;
        o.mwr = MemWrite; o.irw = IRWrite;      o.m2r = MemtoReg; o.rdst = RegDst;
        o.rw = RegWrite;  o.srca = ALUSrcA;     o.srcb = ALUSrcB; o.aluop = ALUOp;
        o.pcsrc = PCSource; o.ill = illegal_op; o.done = instr_done;
        return o;
    endfunction

    function automatic outs_t exp_out(input int st, input logic mr, input logic [5:0] op);
        outs_t o = base[st];
        if (st == 0 && mr) begin o.irw = 1'b1; o.pcw = 1'b1; end
        if (st == 5 && mr) o.done = 1'b1;
        if (st == 1 && !(op inside {LW, SW, RT, BEQ, JMP, ADDI})) begin
            o.ill = 1'b1; o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic load_instr(input logic [5:0] op);
        mop = op;
        case (op)
            LW:      mseq = {0, 1, 2, 3, 4};
            SW:      mseq = {0, 1, 2, 5};
            RT:      mseq = {0, 1, 6, 7};
            BEQ:     mseq = {0, 1, 8};
            JMP:     mseq = {0, 1, 9};
            ADDI:    mseq = {0, 1, 10, 11};
            default: mseq = {0, 1};
        endcase
        mpos = 0;
    endtask

    task automatic cycle(input logic mr);
        outs_t act, exp;
        int st;
        st = mseq[mpos];
        mem_ready = mr;
        Opcode = mop;
        @(negedge clk);
        act = get_outs();
        exp = exp_out(st, mr, mop);
        chk("state", int'(state), st);
        chk("outputs", int'(act), int'(exp));
        if (k < 6) obs_pack[4*k +: 4] = state;
        if (act.done) begin done_cnt++; done_idx = k; end
        if (act.irw) begin irw_cnt++; irw_idx = k; end
        if (act.mrd && state == 4'd0) fetch_rd_cnt++;
        if (act.mwr && act.iord) mwr_cnt++;
        k++;
        // memory states hold while mem_ready is low; everything else always advances
        if (!((st == 0 || st == 3 || st == 5) && !mr)) begin
            mpos++;
            if (mpos == mseq.size()) begin
                mpos = 0;
                instr_end = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int mode, input int fs,
                             input int ms, output int cycles);
        int st;
        logic mr;
        load_instr(op);
        k = 0; done_cnt = 0; done_idx = -1; irw_cnt = 0; irw_idx = -1;
        fetch_rd_cnt = 0; mwr_cnt = 0; obs_pack = '0; instr_end = 1'b0;
        for (int c = 0; c < 80 && !instr_end; c++) begin
            st = mseq[mpos];
            mr = 1'b1;
            if (mode == 1) mr = 1'($urandom_range(0, 1));
            else if (st == 0 && fs > 0) begin mr = 1'b0; fs--; end
            else if ((st == 3 || st == 5) && ms > 0) begin mr = 1'b0; ms--; end
            cycle(mr);
        end
        chk("instr_end", int'(instr_end), 1);
        cycles = k;
    endtask

    initial begin
        int cyc;
        logic [5:0] rop;
        base = '{default: '0};
        base[0].mrd = 1'b1;  base[0].srcb = 2'b01;
        base[1].srcb = 2'b11;
        base[2].srca = 1'b1; base[2].srcb = 2'b10;
        base[3].mrd = 1'b1;  base[3].iord = 1'b1;
        base[4].rw = 1'b1;   base[4].m2r = 1'b1;  base[4].done = 1'b1;
        base[5].mwr = 1'b1;  base[5].iord = 1'b1;
        base[6].srca = 1'b1; base[6].aluop = 2'b10;
        base[7].rw = 1'b1;   base[7].rdst = 1'b1; base[7].done = 1'b1;
        base[8].srca = 1'b1; base[8].aluop = 2'b01; base[8].pcwc = 1'b1;
        base[8].pcsrc = 2'b01; base[8].done = 1'b1;
        base[9].pcw = 1'b1;  base[9].pcsrc = 2'b10; base[9].done = 1'b1;
        base[10].srca = 1'b1; base[10].srcb = 2'b10;
        base[11].rw = 1'b1;  base[11].done = 1'b1;

        vecs[0] = '{LW,   5, 24'h043210};
        vecs[1] = '{SW,   4, 24'h005210};
        vecs[2] = '{RT,   4, 24'h007610};
        vecs[3] = '{BEQ,  3, 24'h000810};
        vecs[4] = '{JMP,  3, 24'h000910};
        vecs[5] = '{ADDI, 4, 24'h00BA10};
        vecs[6] = '{6'b111111, 2, 24'h000010};
        vecs[7] = '{6'b000001, 2, 24'h000010};

        reset_n = 1'b1; mem_ready = 1'b1; Opcode = '0;
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'(get_outs()), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("release_pre_edge_outs", int'(get_outs()), 0);
        @(posedge clk); #1;

        // first instruction right after release: FETCH outputs with IRWrite in cycle 0
        run_instr(RT, 0, 0, 0, cyc);
        chk("release_irw_idx", irw_idx, 0);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, 0, 0, 0, cyc);
            chk("latency", cyc, vecs[i].lat);
            chk("state_seq", int'(obs_pack), int'(vecs[i].states));
            chk("done_count", done_cnt, 1);
        end

        run_instr(RT, 0, 3, 0, cyc);
        chk("fstall_memread_cycles", fetch_rd_cnt, 4);
        chk("fstall_irw_count", irw_cnt, 1);
        chk("fstall_irw_idx", irw_idx, 3);
        chk("fstall_latency", cyc, 7);

        run_instr(SW, 0, 0, 2, cyc);
        chk("swstall_memwrite_cycles", mwr_cnt, 3);
        chk("swstall_done_count", done_cnt, 1);
        chk("swstall_done_idx", done_idx, 5);
        chk("swstall_latency", cyc, 6);

        run_instr(LW, 0, 1, 3, cyc);
        chk("lwstall_latency", cyc, 9);

        // reset asserted mid-instruction while waiting in MEM_READ
        load_instr(LW);
        k = 0; instr_end = 1'b0; done_cnt = 0;
        repeat (3) cycle(1'b1);
        chk("mid_pre_state", int'(state), 3);
        mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_outs", int'(get_outs()), 0);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_done", int'(instr_done), 0);
        chk("mid_rst_memread", int'(MemRead), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_instr(JMP, 0, 0, 0, cyc);
        chk("post_rst_j_latency", cyc, 3);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = BEQ;
                4: rop = JMP;
                5: rop = ADDI;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, 1, 0, 0, cyc);
            chk("rand_done_count", done_cnt, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control FSM for the multi-cycle datapath. It sequences one instruction through fetch, decode, execute, memory and write-back steps, and generates every datapath select and enable in each step:
- ALU operand selects `ALUSrcA`/`ALUSrcB`, which drive the ReadData2/immediate operand mux;
- PC, IR, memory and register-file controls.

It sits between the instruction register's opcode field and the datapath. It also stalls on a memory ready handshake.

## Interface
Parameters:
- `OPCODE_W`, 6, opcode field width.
- `STATE_W`, 4, width of the exported state code.

Ports:
- `clk`  in  1  single clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Opcode`  in  6  IR[31:26], valid from the DECODE state on.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load if ALU Zero (beq).
- `IorD`  out  1  memory address select: 0=PC, 1=ALUOut.
- `MemRead`, `MemWrite`  out  1  memory strobes, held until `mem_ready`.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  write-back data select: 0=ALUOut, 1=MDR.
- `RegDst`  out  1  destination register select: 0=rt, 1=rd.
- `RegWrite`  out  1  register-file write.
- `ALUSrcA`  out  1  0=PC, 1=register A.
- `ALUSrcB`  out  2  00=ReadData2, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- `ALUOp`  out  2  00=add, 01=sub, 10=funct-decoded.
- `PCSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction.
- `state`  out  4  current state code, for debug.

## Operation
States and encodings:
- FETCH(0), DECODE(1), MEM_ADDR(2), MEM_READ(3), MEM_WB(4), MEM_WRITE(5), EXECUTE(6), ALU_WB(7), BRANCH(8), JUMP(9), ADDI_EXEC(10), ADDI_WB(11).

Per-state behaviour:
- **FETCH:** `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` are asserted only when `mem_ready`=1. These two are Mealy outputs.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE:** `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (precomputes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EXEC
  - any other opcode → `illegal_op`=1, `instr_done`=1, next state FETCH (executes as a NOP).
- **MEM_ADDR:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next is MEM_READ (lw) or MEM_WRITE (sw).
- **MEM_READ:** `MemRead`=1, `IorD`=1. Waits for `mem_ready`, then goes to MEM_WB.
- **MEM_WB:** `RegWrite`=1, `MemtoReg`=1, `RegDst`=0, `instr_done`=1. Next is FETCH.
- **MEM_WRITE:** `MemWrite`=1, `IorD`=1. Waits for `mem_ready`; `instr_done`=1 in the cycle `mem_ready`=1, then FETCH.
- **EXECUTE:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next is ALU_WB.
- **ALU_WB:** `RegWrite`=1, `RegDst`=1, `MemtoReg`=0, `instr_done`=1. Next is FETCH.
- **BRANCH:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01, `instr_done`=1. Next is FETCH.
- **JUMP:** `PCWrite`=1, `PCSource`=10, `instr_done`=1. Next is FETCH.
- **ADDI_EXEC:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next is ADDI_WB.
- **ADDI_WB:** `RegWrite`=1, `RegDst`=0, `MemtoReg`=0, `instr_done`=1. Next is FETCH.

Output rules:
- Any output not listed for a state is 0 in that state.
- `Opcode` is sampled only in DECODE and in MEM_ADDR. The IR holds it stable through the rest of the instruction.

## Timing
- **Reset:** `reset_n` low asynchronously forces state=FETCH. While reset is asserted, all outputs are 0, including `MemRead`.
  - After release, the FETCH outputs apply from the first clock edge onward.
  - Reset mid-instruction abandons the instruction. No `instr_done` pulse is produced.
- **Latency with `mem_ready` tied to 1:** beq and j take 3 cycles; R-type, sw and addi take 4; lw takes 5; an illegal opcode takes 2.
- **Wait states:** each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
  - Strobes and address selects stay constant throughout the wait.
  - `IRWrite`/`PCWrite` (in FETCH) and `instr_done` (in MEM_WRITE) do not assert until `mem_ready`=1.
- **Spurious `mem_ready`:** `mem_ready` outside the memory states is ignored.
- **Encoding:** the state register is a binary code; the `state` port equals the encodings listed above.

## Structure
- Package `multicycle_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - `ALUOp` constants;
  - `ALUSrcB` select constants (`SRCB_RD2`, `SRCB_FOUR`, `SRCB_IMM`, `SRCB_IMM_SL2`);
  - `PCSource` constants.
- The operand-mux driver and the datapath use the same package constants.
- One sub-module, `multicycle_ctrl_outputs`: a purely combinational decode of (state, `mem_ready`, `Opcode`) to the output bundle. The top level holds the state register and the next-state logic.

## Test plan
- **Reset:** hold `reset_n`=0 → all outputs 0 and state=0. Release with `mem_ready`=1 → first cycle has `MemRead`=1, `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=01.
- **lw:** `Opcode`=100011, `mem_ready`=1 → state sequence 0,1,2,3,4,0. In state 2, `ALUSrcB`=10. In state 4, `RegWrite`=1 and `MemtoReg`=1. `instr_done` pulses once.
- **R-type, then addi:** R-type → states 0,1,6,7 with `ALUSrcB`=00 and `ALUOp`=10 in state 6. Then addi → states 0,1,10,11 with `ALUSrcB`=10 and `RegDst`=0.
- **Fetch stall:** `mem_ready`=0 for 3 cycles in FETCH → `MemRead` held high for 4 cycles. `IRWrite` pulses only in the 4th cycle, then DECODE.
- **sw stall:** sw with `mem_ready` low for 2 cycles in MEM_WRITE → `MemWrite`=1 and `IorD`=1 held for 3 cycles. `instr_done` pulses only in the `mem_ready` cycle.
- **Branch, jump, illegal, mid-instruction reset:** beq → `PCWriteCond`=1, `ALUOp`=01, `PCSource`=01 in state 8. j → `PCWrite`=1, `PCSource`=10 in state 9. Opcode 111111 → `illegal_op` pulses in DECODE, then FETCH. `reset_n` pulsed low in state 3 → state=0 immediately and no `instr_done`.
